// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared encodings for the SRAM controller and its lane aligner.
// Contents: request size codes, controller FSM state enum, request error check.
// No ports; imported by sram_lane_align and sram_ctrl.
package sram_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_RESP
  } state_e;

  // The illegal size code is reported here too, so one call covers every
  // condition that turns a request into an error response.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sram_lane_align.sv
// sram_lane_align: byte/halfword lane steering for stores, extraction and extension for loads.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: st_* = store size/offset/data in, strobes/replicated data out;
//        ld_* = load size/offset/unsigned/raw RAM word in, extended data out.
module sram_lane_align
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_wea_o,
  output logic [31:0] st_dina_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store: data is replicated across all lanes so the strobes alone pick the target bytes.
  always_comb begin
    st_wea_o  = 4'b1111;
    st_dina_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_wea_o  = 4'b0001 << st_off_i;
        st_dina_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_wea_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_dina_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = ld_word_i[{ld_off_i, 3'b000} +: 8];
  assign half_sel = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    ld_rdata_o = ld_word_i;
    case (ld_size_i)
      SZ_BYTE: ld_rdata_o = {{24{~ld_unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_rdata_o = {{16{~ld_unsigned_i & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-outstanding load/store controller for a simple dual-port block RAM.
// Latency: store rsp at T+2, load rsp at T+2+READ_LATENCY, error rsp at T+1 after handshake.
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no backpressure.
// Ports: req_* core request channel, rsp_* response pulse, ram_* RAM port A (write) / port B (read).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        ram_ena,
  output logic [3:0]  ram_wea,
  output logic [31:0] ram_addra,
  output logic [31:0] ram_dina,
  output logic        ram_enb,
  output logic        ram_rstb,
  output logic [31:0] ram_addrb,
  input  logic [31:0] ram_doutb,
  input  logic        ram_rsta_busy,
  input  logic        ram_rstb_busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        uns_q, uns_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        ena_q, ena_d;
  logic [3:0]  wea_q, wea_d;
  logic [31:0] addra_q, addra_d;
  logic [31:0] dina_q, dina_d;
  logic        enb_q, enb_d;
  logic        rstb_q, rstb_d;
  logic [31:0] addrb_q, addrb_d;

  logic        hs;
  logic        req_bad;
  logic        busy;
  logic [3:0]  st_wea;
  logic [31:0] st_dina;
  logic [31:0] ld_rdata;

  assign hs      = (state_q == ST_IDLE) && ready_q && req_valid;
  assign req_bad = is_misaligned(req_size, req_addr[1:0]);
  assign busy    = ram_rsta_busy | ram_rstb_busy;

  // Store steering works on the live request (registered at the handshake edge);
  // load extraction works on the fields latched at the handshake.
  sram_lane_align u_align (
    .st_size_i    (req_size),
    .st_off_i     (req_addr[1:0]),
    .st_wdata_i   (req_wdata),
    .st_wea_o     (st_wea),
    .st_dina_o    (st_dina),
    .ld_size_i    (size_q),
    .ld_off_i     (off_q),
    .ld_unsigned_i(uns_q),
    .ld_word_i    (ram_doutb),
    .ld_rdata_o   (ld_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = 2'd0;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    ena_d       = 1'b0;
    wea_d       = 4'h0;
    addra_d     = 32'h0;
    dina_d      = 32'h0;
    enb_d       = 1'b0;
    rstb_d      = 1'b0;
    addrb_d     = 32'h0;
    case (state_q)
      // rstb_q is only high in the very first post-reset cycle.
      ST_INIT: if (!rstb_q && !busy) state_d = ST_IDLE;
      ST_IDLE: begin
        // An accepted request wins over a simultaneous busy rise; it completes first.
        if (hs) begin
          size_d = req_size;
          off_d  = req_addr[1:0];
          uns_d  = req_unsigned;
          if (req_bad) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d = ST_WRITE;
            ena_d   = 1'b1;
            wea_d   = st_wea;
            dina_d  = st_dina;
            addra_d = {req_addr[31:2], 2'b00};
          end else begin
            state_d = ST_READ_WAIT;
            enb_d   = 1'b1;
            addrb_d = {req_addr[31:2], 2'b00};
          end
        end else if (busy) begin
          state_d = ST_INIT;
        end
      end
      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
      // cnt_q counts cycles since ram_enb was presented; data is valid once it reaches the latency.
      ST_READ_WAIT: begin
        if (cnt_q == 2'(READ_LATENCY)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ld_rdata;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
    // Registered ready: high in the cycle the FSM sits in IDLE with the RAM out of reset.
    ready_d = (state_d == ST_IDLE) && !busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= 2'd0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      uns_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      ena_q       <= 1'b0;
      wea_q       <= 4'h0;
      addra_q     <= 32'h0;
      dina_q      <= 32'h0;
      enb_q       <= 1'b0;
      rstb_q      <= 1'b1;
      addrb_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      enb_q       <= enb_d;
      rstb_q      <= rstb_d;
      addrb_q     <= addrb_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_ena   = ena_q;
  assign ram_wea   = wea_q;
  assign ram_addra = addra_q;
  assign ram_dina  = dina_q;
  assign ram_enb   = enb_q;
  assign ram_rstb  = rstb_q;
  assign ram_addrb = addrb_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl with a behavioural dual-port RAM
// and a byte-array reference model of memory contents and load/store rules.
module tb_sram_ctrl;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_ena, ram_enb, ram_rstb;
  logic [3:0]  ram_wea;
  logic [31:0] ram_addra, ram_dina, ram_addrb, ram_doutb;
  logic        ram_rsta_busy, ram_rstb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl #(.READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_enb(ram_enb), .ram_rstb(ram_rstb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .ram_rsta_busy(ram_rsta_busy), .ram_rstb_busy(ram_rstb_busy)
  );

  // Behavioural RAM: 64 words, port A byte-write, port B read with RL-cycle latency and output reset.
  logic [31:0] ram_mem  [0:63];
  logic [31:0] seed_mem [0:63];
  logic        load_seed;
  logic [31:0] rd1, rd2;

  always @(posedge clk) begin
    if (load_seed) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= seed_mem[i];
    end else if (ram_ena) begin
      for (int b = 0; b < 4; b++)
        if (ram_wea[b]) ram_mem[ram_addra[7:2]][b*8 +: 8] <= ram_dina[b*8 +: 8];
    end
    if (ram_rstb) begin
      rd1 <= 32'h0;
      rd2 <= 32'h0;
    end else begin
      if (ram_enb) rd1 <= ram_mem[ram_addrb[7:2]];
      rd2 <= rd1;
    end
  end
  assign ram_doutb = (RL == 2) ? rd2 : rd1;

  logic any_out;
  assign any_out = req_ready | rsp_valid | rsp_err | (|rsp_rdata) | ram_ena | (|ram_wea) |
                   (|ram_addra) | (|ram_dina) | ram_enb | (|ram_addrb);

  // Reference model: flat byte memory, aliased to 256 bytes like the RAM model.
  logic [7:0] ref_mem [0:255];

  function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    if (size == 2'd3) return 1'b1;
    n = 1 << size;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr, input logic uns);
    int n, base;
    logic [31:0] v;
    n = 1 << size;
    base = int'(addr[7:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(base + i) & 255]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd);
    int n, base;
    n = 1 << size;
    base = int'(addr[7:0]);
    for (int i = 0; i < n; i++) ref_mem[(base + i) & 255] = wd[8*i +: 8];
  endtask

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          n_ena, n_enb, ena_at, enb_at, n_rdy;
    logic [3:0]  wea;
    logic [31:0] dina, addr;
  } obs_t;

  // Drives one request, then scrambles the request inputs and records what the DUT does.
  // Cycle k in the record is k cycles after the handshake cycle.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, output obs_t o);
    int w;
    o.lat = -1; o.err = 1'b0; o.rd = 32'h0; o.n_ena = 0; o.n_enb = 0;
    o.ena_at = -1; o.enb_at = -1; o.n_rdy = 0; o.wea = 4'h0; o.dina = 32'h0; o.addr = 32'h0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin o.lat = -2; return; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (req_ready) o.n_rdy++;
      if (ram_ena) begin o.n_ena++; o.ena_at = k; o.wea = ram_wea; o.dina = ram_dina; o.addr = ram_addra; end
      if (ram_enb) begin o.n_enb++; o.enb_at = k; o.addr = ram_addrb; end
      if (rsp_valid) begin o.lat = k; o.err = rsp_err; o.rd = rsp_rdata; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ram_rsta_busy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL rst_outs: got any_out=%b expected 0", any_out); end
    checks++; if (ram_rstb !== 1'b1) begin errors++; $display("FAIL rst_rstb: got %b expected 1", ram_rstb); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c == 5) ram_rsta_busy = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'(c == 6)) begin errors++; $display("FAIL rst_ready c%0d: got %b expected %b", c, req_ready, c == 6); end
      checks++; if (ram_rstb !== 1'(c == 0)) begin errors++; $display("FAIL rst_rstb c%0d: got %b expected %b", c, ram_rstb, c == 0); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_byte();
    obs_t o;
    issue(1'b1, 32'h13, 2'd0, 1'b0, 32'h1234_56A5, o);
    ref_store(2'd0, 32'h13, 32'h1234_56A5);
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL sb_lat: got %0d expected 2", o.lat); end
    checks++; if (o.ena_at !== 1 || o.n_ena !== 1 || o.n_enb !== 0) begin errors++; $display("FAIL sb_ena: got at=%0d n=%0d nb=%0d expected 1 1 0", o.ena_at, o.n_ena, o.n_enb); end
    checks++; if (o.wea !== 4'b1000) begin errors++; $display("FAIL sb_wea: got %b expected 1000", o.wea); end
    checks++; if (o.dina !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_dina: got %h expected a5a5a5a5", o.dina); end
    checks++; if (o.addr !== 32'h10) begin errors++; $display("FAIL sb_addr: got %h expected 00000010", o.addr); end
    checks++; if (o.err !== 1'b0 || o.rd !== 32'h0) begin errors++; $display("FAIL sb_rsp: got err=%b rd=%h expected 0 0", o.err, o.rd); end
    issue(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, o);
    checks++; if (o.lat !== 2 + RL) begin errors++; $display("FAIL lbs_lat: got %0d expected %0d", o.lat, 2 + RL); end
    checks++; if (o.enb_at !== 1 || o.n_enb !== 1 || o.n_ena !== 0) begin errors++; $display("FAIL lbs_enb: got at=%0d n=%0d na=%0d expected 1 1 0", o.enb_at, o.n_enb, o.n_ena); end
    checks++; if (o.addr !== 32'h10) begin errors++; $display("FAIL lbs_addr: got %h expected 00000010", o.addr); end
    checks++; if (o.rd !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lbs_data: got %h expected ffffffa5", o.rd); end
    issue(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, o);
    checks++; if (o.rd !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_data: got %h expected 000000a5", o.rd); end
  endtask

  task automatic test_half_word();
    obs_t o;
    issue(1'b1, 32'h22, 2'd1, 1'b0, 32'h5A5A_8001, o);
    ref_store(2'd1, 32'h22, 32'h5A5A_8001);
    checks++; if (o.wea !== 4'b1100) begin errors++; $display("FAIL sh_wea: got %b expected 1100", o.wea); end
    checks++; if (o.dina !== 32'h8001_8001) begin errors++; $display("FAIL sh_dina: got %h expected 80018001", o.dina); end
    issue(1'b0, 32'h22, 2'd1, 1'b0, 32'h0, o);
    checks++; if (o.rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data: got %h expected ffff8001", o.rd); end
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEAD_BEEF, o);
    ref_store(2'd2, 32'h40, 32'hDEAD_BEEF);
    checks++; if (o.wea !== 4'b1111 || o.dina !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_port: got wea=%b dina=%h expected 1111 deadbeef", o.wea, o.dina); end
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, o);
    checks++; if (o.rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", o.rd); end
    checks++; if (o.lat !== 2 + RL) begin errors++; $display("FAIL lw_lat: got %0d expected %0d", o.lat, 2 + RL); end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [31:0] a [3];
    logic [1:0]  s [3];
    a[0] = 32'h21; s[0] = 2'd1;
    a[1] = 32'h42; s[1] = 2'd2;
    a[2] = 32'h40; s[2] = 2'd3;
    for (int i = 0; i < 6; i++) begin
      issue(1'(i % 2), a[i/2], s[i/2], 1'b0, 32'hFFFF_FFFF, o);
      checks++; if (o.lat !== 1 || o.err !== 1'b1) begin errors++; $display("FAIL err%0d_rsp: got lat=%0d err=%b expected 1 1", i, o.lat, o.err); end
      checks++; if (o.rd !== 32'h0 || o.n_ena !== 0 || o.n_enb !== 0) begin errors++; $display("FAIL err%0d_side: got rd=%h ena=%0d enb=%0d expected 0 0 0", i, o.rd, o.n_ena, o.n_enb); end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic we, uns, e;
    logic [1:0] sz;
    logic [31:0] a, wd, exp_dina;
    logic [3:0] exp_wea;
    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255)); wd = $urandom;
      e = ref_err(sz, a);
      issue(we, a, sz, uns, wd, o);
      checks++; if (o.err !== e || o.lat !== (e ? 1 : (we ? 2 : 2 + RL))) begin errors++; $display("FAIL rnd%0d_rsp: got err=%b lat=%0d expected err=%b", t, o.err, o.lat, e); end
      checks++; if (o.n_ena !== ((!e && we) ? 1 : 0) || o.n_enb !== ((!e && !we) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_en: got ena=%0d enb=%0d", t, o.n_ena, o.n_enb); end
      if (!e && we) begin
        exp_wea = 4'(((1 << (1 << sz)) - 1) << int'(a[1:0]));
        exp_dina = (sz == 2'd0) ? wd[7:0] * 32'h0101_0101 : (sz == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;
        checks++; if (o.wea !== exp_wea || o.dina !== exp_dina || o.addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rnd%0d_st: got wea=%b dina=%h addr=%h expected %b %h %h", t, o.wea, o.dina, o.addr, exp_wea, exp_dina, a & 32'hFFFF_FFFC); end
        ref_store(sz, a, wd);
      end else begin
        checks++; if (o.rd !== (e ? 32'h0 : ref_load(sz, a, uns))) begin errors++; $display("FAIL rnd%0d_rd: got %h expected %h", t, o.rd, e ? 32'h0 : ref_load(sz, a, uns)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_addr [4];
    logic [1:0]  b_size [4];
    logic        b_uns  [4];
    logic [31:0] b_exp  [4];
    int hs_cyc [4];
    int hs, rsp, outst, cyc;
    for (int i = 0; i < 4; i++) begin
      b_size[i] = 2'($urandom_range(0, 2));
      b_addr[i] = 32'($urandom_range(0, 255));
      b_addr[i] = b_addr[i] & ~((32'd1 << b_size[i]) - 32'd1);
      b_uns[i]  = 1'($urandom);
      b_exp[i]  = ref_load(b_size[i], b_addr[i], b_uns[i]);
    end
    hs = 0; rsp = 0; outst = 0; cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = b_addr[0]; req_size = b_size[0]; req_unsigned = b_uns[0];
    while (rsp < 4 && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        checks++; if (rsp_rdata !== b_exp[rsp] || rsp_err !== 1'b0) begin errors++; $display("FAIL b2b_rsp%0d: got %h err=%b expected %h", rsp, rsp_rdata, rsp_err, b_exp[rsp]); end
        rsp++; outst--;
      end
      checks++; if ((req_ready && outst != 0) !== 1'b0) begin errors++; $display("FAIL b2b_ready_gap: got ready=1 with %0d outstanding expected 0", outst); end
      if (req_ready && req_valid) begin
        hs_cyc[hs] = cyc; hs++; outst++;
      end
      @(posedge clk); #1;
      if (hs >= 4) req_valid = 1'b0;
      else begin req_addr = b_addr[hs]; req_size = b_size[hs]; req_unsigned = b_uns[hs]; end
    end
    req_valid = 1'b0;
    checks++; if (rsp !== 4 || hs !== 4) begin errors++; $display("FAIL b2b_count: got rsp=%0d hs=%0d expected 4 4", rsp, hs); end
    for (int i = 1; i < hs; i++) begin
      checks++; if (hs_cyc[i] - hs_cyc[i-1] !== 3 + RL) begin errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", i, hs_cyc[i] - hs_cyc[i-1], 3 + RL); end
    end
  endtask

  task automatic test_busy_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    ram_rstb_busy = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c == 3) ram_rstb_busy = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'(c == 0 || c == 4)) begin errors++; $display("FAIL busy_ready c%0d: got %b expected %b", c, req_ready, c == 0 || c == 4); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_rwait();
    int w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (ram_enb !== 1'b1) begin errors++; $display("FAIL rrw_enb: got %b expected 1", ram_enb); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (any_out !== 1'b0 || ram_rstb !== 1'b1) begin errors++; $display("FAIL rrw_outs: got any_out=%b rstb=%b expected 0 1", any_out, ram_rstb); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rrw_norsp c%0d: got %b expected 0", c, rsp_valid); end
      checks++; if (req_ready !== 1'(c >= 2)) begin errors++; $display("FAIL rrw_ready c%0d: got %b expected %b", c, req_ready, c >= 2); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    ram_rsta_busy = 1'b0; ram_rstb_busy = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      seed_mem[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = seed_mem[i][8*b +: 8];
    end
    load_seed = 1'b1;
    @(posedge clk); #1;
    load_seed = 1'b0;
    test_reset();
    test_byte();
    test_half_word();
    test_errors();
    test_random();
    test_back_to_back();
    test_busy_idle();
    test_reset_rwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-outstanding memory controller that turns core load/store requests into port-level accesses on the simple dual-port block RAM (port A write-only, port B read-only with output reset). It sits between the core's data-memory request channel and the RAM: it drives the RAM's enables, byte strobes, addresses and write data, and collects read data. It also handles byte/halfword lane steering, load sign extension, misalignment detection, RAM read latency and RAM reset-busy sequencing.

## Interface
Parameters:
- READ_LATENCY, 1, RAM port-B read latency in cycles; only 1 and 2 are legal.

Ports:
- clk  in  1  single clock for the controller and both RAM ports.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads when 1.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse, no backpressure.
- rsp_err  out  1  misaligned or illegal size; qualified by rsp_valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- ram_ena  out  1 / ram_wea  out  4 / ram_addra  out  32 / ram_dina  out  32  port-A write controls.
- ram_enb  out  1 / ram_rstb  out  1 / ram_addrb  out  32  port-B read controls.
- ram_doutb  in  32  port-B read data.
- ram_rsta_busy  in  1 / ram_rstb_busy  in  1  RAM reset-busy flags.

## Operation
- All outputs are registered. Reset value of every output is 0, except ram_rstb, which is 1.
- FSM states: INIT, IDLE, WRITE, READ_WAIT, RESP.
  - INIT: ram_rstb is high for the first cycle after reset, then low. Go to IDLE once ram_rstb is low and both busy flags are low.
  - IDLE: req_ready=1. On handshake:
    - Error check first. Error if req_size=11, or half with addr[0]≠0, or word with addr[1:0]≠0.
    - Error → RESP with err=1.
    - No error, store → WRITE.
    - No error, load → READ_WAIT.
  - WRITE: pulse ram_ena=1 with the strobes and data below. Go to RESP.
  - READ_WAIT: pulse ram_enb=1 in the first cycle. Count READ_LATENCY cycles, then capture ram_doutb and go to RESP.
  - RESP: rsp_valid=1 for one cycle. Go to IDLE.
- RAM addresses are {req_addr[31:2],2'b00}.
- Store lane steering:
  - byte: dina={4{wdata[7:0]}}, wea=4'b0001<<addr[1:0].
  - half: dina={2{wdata[15:0]}}, wea=addr[1] ? 1100 : 0011.
  - word: dina=wdata, wea=1111.
- Load extract:
  - Select the byte or half at addr[1:0] from the captured word.
  - Sign-extend unless req_unsigned=1. Word loads pass through unchanged.
- Request fields are latched at the handshake; later changes to the request inputs are ignored.
- Busy flag rising in IDLE: req_ready drops and the FSM returns to INIT. An in-progress access is always allowed to complete first.
- rst_n low in any state: next cycle is INIT with reset output values. Any in-flight response is dropped and never emitted.
- ram_ena and ram_enb are never high in the same cycle, so there is no RAM collision hazard.

## Timing
- Handshake at cycle T.
- Store: ram_ena/wea at T+1; rsp_valid at T+2.
- Load: ram_enb at T+1; data captured at the end of T+1+READ_LATENCY; rsp_valid at T+2+READ_LATENCY.
- Error: rsp_valid with rsp_err=1 at T+1; no RAM enable is asserted.
- req_ready returns at the cycle after rsp_valid.
- Throughput:
  - one store per 3 cycles;
  - one load per 3+READ_LATENCY cycles.
- After reset release, the earliest req_ready is 2 cycles later when the busy flags are already low.

## Structure
- Shared package sram_ctrl_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - function is_misaligned(size, addr[1:0]).
- Sub-module sram_lane_align, purely combinational, with two paths:
  - store path: size + offset + wdata → wea + dina;
  - load path: size + offset + unsigned + word → rdata.

## Test plan
- Reset with ram_rsta_busy held high for 5 cycles → req_ready stays 0 until 1 cycle after busy falls; ram_rstb=1 only in the first post-reset cycle.
- Store byte 0xA5 at 0x0000_0013 → wea=1000, dina=0xA5A5A5A5, addra=0x10, rsp_valid at T+2. Then load signed byte from 0x13 → rsp_rdata=0xFFFF_FFA5; unsigned → 0x0000_00A5.
- Store half 0x8001 at 0x22, then load signed half → wea=1100, rsp_rdata=0xFFFF_8001. Store word 0xDEADBEEF at 0x40, then load word → 0xDEADBEEF, with rsp_valid at T+3 (READ_LATENCY=1) and T+4 (READ_LATENCY=2).
- Half at 0x21, word at 0x42, size=11 → rsp_err=1 at T+1, rsp_rdata=0, no ram_ena/ram_enb pulse.
- Back-to-back: req_valid held high with 4 loads → exactly one outstanding, req_ready low between handshakes, responses in order.
- rst_n low in READ_WAIT → no rsp_valid follows, outputs at reset values next cycle, FSM back in INIT.
